// File: rtl/alu_pkg.sv
// Shared opcode, condition-code, flag-index and FSM-state definitions for the
// execute-stage sequencer and anything else that decodes ALU instructions.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_ORR    = 4'd4;
    localparam logic [3:0] OP_EOR    = 4'd5;
    localparam logic [3:0] OP_MOV    = 4'd6;
    localparam logic [3:0] OP_MVN    = 4'd7;
    localparam logic [3:0] OP_LSL    = 4'd8;
    localparam logic [3:0] OP_LSR    = 4'd9;
    localparam logic [3:0] OP_ADDI   = 4'd10;
    localparam logic [3:0] OP_SETF   = 4'd11;
    localparam logic [3:0] OP_RSV_LO = 4'd12;
    localparam logic [3:0] OP_RSV_HI = 4'd15;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic is_reserved(input logic [3:0] op);
        return (op >= OP_RSV_LO) && (op <= OP_RSV_HI);
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Issue, ALU and writeback signal bundle around the execute sequencer.
// slave = sequencer side, master = decode/ALU/register-file side.
interface alu_exec_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              issue_valid;
    logic              issue_ready;
    logic [3:0]        issue_opcode;
    logic [3:0]        issue_cond;
    logic              issue_s;
    logic [3:0]        issue_rd;
    logic [DATA_W-1:0] issue_rn;
    logic [DATA_W-1:0] issue_rm;
    logic [15:0]       issue_iv;

    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [15:0]       alu_iv;
    logic              alu_s;
    logic [3:0]        alu_flag;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_new_flag;

    logic              wb_valid;
    logic              wb_ready;
    logic              wb_we;
    logic [3:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic [3:0]        flags;
    logic              illegal;

    modport slave (
        input  issue_valid, issue_opcode, issue_cond, issue_s, issue_rd,
               issue_rn, issue_rm, issue_iv, alu_result, alu_new_flag, wb_ready,
        output issue_ready, alu_opcode, alu_a, alu_b, alu_iv, alu_s, alu_flag,
               wb_valid, wb_we, wb_rd, wb_data, flags, illegal
    );

    modport master (
        output issue_valid, issue_opcode, issue_cond, issue_s, issue_rd,
               issue_rn, issue_rm, issue_iv, alu_result, alu_new_flag, wb_ready,
        input  issue_ready, alu_opcode, alu_a, alu_b, alu_iv, alu_s, alu_flag,
               wb_valid, wb_we, wb_rd, wb_data, flags, illegal
    );
endinterface

// File: rtl/alu_exec_ctrl_cond_eval.sv
// Combinational ARM-style condition evaluation against NZCV flags.
// Kept standalone so the branch unit can share it.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;

    always_comb begin
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: accepts one instruction, drives the external ALU,
// waits out MUL, then offers the result to writeback and commits NZCV on handshake.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int DATA_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_exec_ctrl_if.slave  bus
);
    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic              cond_pass_reg;
    logic [3:0]        rd_reg;
    logic [3:0]        opcode_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [15:0]       iv_reg;
    logic              s_reg;
    logic [3:0]        flags_reg;
    logic [3:0]        flag_cap_reg;
    logic              commit_reg;
    logic              wb_valid_reg;
    logic              wb_we_reg;
    logic [3:0]        wb_rd_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic              illegal_reg;

    logic issue_pass;
    logic op_reserved;
    logic do_capture;
    logic do_skip;

    cond_eval u_cond_eval (
        .cond  (bus.issue_cond),
        .flags (flags_reg),
        .pass  (issue_pass)
    );

    // A failed condition wins over a reserved opcode: nothing executes, no illegal pulse.
    always_comb begin
        op_reserved = is_reserved(opcode_reg);
        do_skip     = (state_reg == ST_EXEC) && (!cond_pass_reg || op_reserved);
        do_capture  = 1'b0;
        if (state_reg == ST_EXEC && cond_pass_reg && !op_reserved)
            do_capture = (opcode_reg != OP_MUL) || (MUL_LAST == 4'd0);
        else if (state_reg == ST_WAIT)
            do_capture = (cnt_reg == 4'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            cond_pass_reg <= 1'b0;
            rd_reg        <= '0;
            opcode_reg    <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            iv_reg        <= '0;
            s_reg         <= 1'b0;
            flags_reg     <= '0;
            flag_cap_reg  <= '0;
            commit_reg    <= 1'b0;
            wb_valid_reg  <= 1'b0;
            wb_we_reg     <= 1'b0;
            wb_rd_reg     <= '0;
            wb_data_reg   <= '0;
            illegal_reg   <= 1'b0;
        end else begin
            illegal_reg <= (state_reg == ST_EXEC) && cond_pass_reg && op_reserved;

            if (do_capture || do_skip) begin
                wb_valid_reg <= 1'b1;
                wb_rd_reg    <= rd_reg;
                wb_we_reg    <= do_capture && (opcode_reg != OP_SETF);
                commit_reg   <= do_capture && (s_reg || opcode_reg == OP_SETF);
                flag_cap_reg <= bus.alu_new_flag;
                if (do_capture)
                    wb_data_reg <= bus.alu_result;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (bus.issue_valid) begin
                        opcode_reg    <= bus.issue_opcode;
                        a_reg         <= bus.issue_rn;
                        b_reg         <= bus.issue_rm;
                        iv_reg        <= bus.issue_iv;
                        s_reg         <= bus.issue_s;
                        rd_reg        <= bus.issue_rd;
                        cond_pass_reg <= issue_pass;
                        state_reg     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (do_capture || do_skip) begin
                        state_reg <= ST_WB;
                    end else begin
                        cnt_reg   <= MUL_LAST;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (do_capture)
                        state_reg <= ST_WB;
                end
                ST_WB: begin
                    if (bus.wb_ready) begin
                        wb_valid_reg <= 1'b0;
                        if (commit_reg)
                            flags_reg <= flag_cap_reg;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.issue_ready = (state_reg == ST_IDLE);
    assign bus.alu_opcode  = opcode_reg;
    assign bus.alu_a       = a_reg;
    assign bus.alu_b       = b_reg;
    assign bus.alu_iv      = iv_reg;
    assign bus.alu_s       = s_reg;
    assign bus.alu_flag    = flags_reg;
    assign bus.wb_valid    = wb_valid_reg;
    assign bus.wb_we       = wb_we_reg;
    assign bus.wb_rd       = wb_rd_reg;
    assign bus.wb_data     = wb_data_reg;
    assign bus.flags       = flags_reg;
    assign bus.illegal     = illegal_reg;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed + random bench for alu_exec_ctrl with a behavioural ALU that only
// yields a valid MUL result once its operands have been held MUL_CYCLES cycles.
module tb_alu_exec_ctrl;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int MC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_exec_ctrl_if #(.DATA_W(DW)) bus ();

    alu_exec_ctrl #(.MUL_CYCLES(MC), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [3:0] mflags;
    int settle = 0;
    logic [35:0] alu_r;

    function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] iv,
                                            input logic [3:0] fl);
        logic [32:0] w;
        logic [31:0] r;
        logic c, v;
        logic [3:0] nf;
        w = '0; r = '0; c = fl[1]; v = fl[0];
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                        v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a * b;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = b;
            4'd7: r = ~b;
            4'd8: r = a << b[4:0];
            4'd9: r = a >> b[4:0];
            4'd10: begin w = {1'b0, a} + {17'b0, iv}; r = w[31:0]; c = w[32];
                         v = !a[31] && r[31]; end
            default: r = '0;
        endcase
        nf = {r[31], (r == 32'd0), c, v};
        if (op == 4'd11) nf = iv[3:0];
        if (op >= 4'd12) nf = fl;
        return {nf, r};
    endfunction

    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] fl);
        logic n, z, c, v;
        {n, z, c, v} = fl;
        case (cond)
            4'h0: return z;            4'h1: return !z;
            4'h2: return c;            4'h3: return !c;
            4'h4: return n;            4'h5: return !n;
            4'h6: return v;            4'h7: return !v;
            4'h8: return c && !z;      4'h9: return !c || z;
            4'hA: return n == v;       4'hB: return n != v;
            4'hC: return !z && n == v; 4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Cycles the ALU inputs have been held since the last accepted instruction.
    always @(negedge clk) begin
        if (bus.issue_valid && bus.issue_ready) settle <= 0;
        else if (settle < 255) settle <= settle + 1;
    end

    always_comb begin
        alu_r = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_iv, bus.alu_flag);
        if (bus.alu_opcode == OP_MUL && settle < MC)
            alu_r = alu_r ^ 36'hF_DEAD_BEEF;
    end
    assign bus.alu_result   = alu_r[31:0];
    assign bus.alu_new_flag = alu_r[35:32];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_issue(input logic [3:0] op, input logic [3:0] cond, input logic s,
                               input logic [3:0] rd, input logic [31:0] rn,
                               input logic [31:0] rm, input logic [15:0] iv);
        bus.issue_valid  = 1'b1;
        bus.issue_opcode = op;
        bus.issue_cond   = cond;
        bus.issue_s      = s;
        bus.issue_rd     = rd;
        bus.issue_rn     = rn;
        bus.issue_rm     = rm;
        bus.issue_iv     = iv;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] cond, input logic s,
                             input logic [3:0] rd, input logic [31:0] rn,
                             input logic [31:0] rm, input logic [15:0] iv, input int hold);
        logic pass, exp_we, exp_ill;
        logic [35:0] er;
        logic [3:0] exp_fl;
        int exp_lat, lat, ill;
        pass    = cond_ok(cond, mflags);
        er      = alu_ref(op, rn, rm, iv, mflags);
        exp_we  = pass && (op <= OP_ADDI);
        exp_ill = pass && (op >= OP_RSV_LO);
        exp_lat = (pass && op == OP_MUL) ? MC : 1;
        exp_fl  = (pass && op <= OP_SETF && (s || op == OP_SETF)) ? er[35:32] : mflags;

        check("issue_ready_idle", 64'(bus.issue_ready), 64'(1));
        drive_issue(op, cond, s, rd, rn, rm, iv);
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
        check("issue_ready_busy", 64'(bus.issue_ready), 64'(0));
        lat = 0; ill = 0;
        while (!bus.wb_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.illegal) ill++;
        end
        check("wb_latency", 64'(lat), 64'(exp_lat));
        check("wb_we", 64'(bus.wb_we), 64'(exp_we));
        check("wb_rd", 64'(bus.wb_rd), 64'(rd));
        if (exp_we) check("wb_data", 64'(bus.wb_data), 64'(er[31:0]));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (bus.illegal) ill++;
            check("bp_wb_valid", 64'(bus.wb_valid), 64'(1));
            check("bp_issue_ready", 64'(bus.issue_ready), 64'(0));
            check("bp_wb_we", 64'(bus.wb_we), 64'(exp_we));
            check("bp_wb_rd", 64'(bus.wb_rd), 64'(rd));
            if (exp_we) check("bp_wb_data", 64'(bus.wb_data), 64'(er[31:0]));
            check("bp_flags_early", 64'(bus.flags), 64'(mflags));
        end
        bus.wb_ready = 1'b1;
        @(posedge clk); #1;
        bus.wb_ready = 1'b0;
        if (bus.illegal) ill++;
        mflags = exp_fl;
        check("flags_commit", 64'(bus.flags), 64'(mflags));
        check("wb_valid_drop", 64'(bus.wb_valid), 64'(0));
        check("issue_ready_back", 64'(bus.issue_ready), 64'(1));
        check("illegal_pulses", 64'(ill), 64'(exp_ill));
        $display("[TB] op=%h cond=%h s=%0d pass=%0d lat=%0d we=%0d flags=%h hold=%0d",
                 op, cond, s, pass, lat, exp_we, mflags, hold);
    endtask

    initial begin
        mflags = 4'h0;
        bus.wb_ready = 1'b0;
        drive_issue(4'h0, 4'h0, 1'b0, 4'h0, 32'h0, 32'h0, 16'h0);
        bus.issue_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_issue_ready", 64'(bus.issue_ready), 64'(1));
        check("rst_wb_valid", 64'(bus.wb_valid), 64'(0));
        check("rst_flags", 64'(bus.flags), 64'(0));
        check("rst_illegal", 64'(bus.illegal), 64'(0));
        check("rst_wb_we", 64'(bus.wb_we), 64'(0));
        check("rst_alu_opcode", 64'(bus.alu_opcode), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(OP_ADD, COND_AL, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'd1, 16'h0, 0);
        check("add_flags_0110", 64'(bus.flags), 64'(4'b0110));
        run_instr(OP_SETF, COND_AL, 1'b0, 4'd1, 32'd0, 32'd0, 16'h0009, 0);
        check("setf_flags_1001", 64'(bus.flags), 64'(4'b1001));
        run_instr(OP_ADD, COND_EQ, 1'b1, 4'd5, 32'd10, 32'd20, 16'h0, 0);
        run_instr(OP_MUL, COND_AL, 1'b0, 4'd7, 32'd7, 32'd6, 16'h0, 0);
        run_instr(4'b1110, COND_AL, 1'b1, 4'd2, 32'd1, 32'd2, 16'h0, 0);
        run_instr(OP_ADD, COND_AL, 1'b0, 4'd9, 32'h1234, 32'h1111, 16'h0, 5);

        // Reset while the MUL is waiting: nothing may reach writeback.
        drive_issue(OP_MUL, COND_AL, 1'b1, 4'd4, 32'd3, 32'd5, 16'h0);
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mflags = 4'h0;
        check("rstmul_wb_valid", 64'(bus.wb_valid), 64'(0));
        check("rstmul_flags", 64'(bus.flags), 64'(0));
        check("rstmul_issue_ready", 64'(bus.issue_ready), 64'(1));
        check("rstmul_alu_a", 64'(bus.alu_a), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rstmul_no_wb", 64'(bus.wb_valid), 64'(0));
        end

        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            logic [31:0] rn, rm;
            op = 4'($urandom_range(0, 15));
            rn = $urandom();
            rm = $urandom();
            if (op == OP_MUL) begin
                rn = 32'($urandom_range(0, 70000));
                rm = 32'($urandom_range(0, 70000));
            end
            run_instr(op, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), rn, rm, 16'($urandom()),
                      $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
